f64mul_share_sched: RTL

- Shares one pipelined IEEE-754 binary64 multiplier among NREQ requesters.
- Round-robin arbitration issues at most one operand pair per cycle. Results are tagged with the requester id and returned in issue order through a credit-protected result FIFO with valid/ready backpressure.
- Sits between the requesting datapaths (dot-product and accumulator lanes) and the shared multiply resource.

---
 rtl/f64mul_pkg.sv | 66 ++++++
 rtl/f64mul_pipe.sv | 65 ++++++
 rtl/f64mul_share_sched.sv | 133 +++++++++++++
 3 files changed

// File: rtl/f64mul_pkg.sv
// Shared types, constants and the combinational binary64 multiply core.
package f64mul_pkg;

  localparam int F64_W    = 64;
  localparam int EXP_W    = 11;
  localparam int FRAC_W   = 52;
  localparam int ID_MAX_W = 8;

  localparam logic [F64_W-1:0] CANON_NAN = 64'h7FF8000000000000;
  localparam logic [EXP_W-1:0] EXP_MAX   = 11'h7FF;

  typedef logic [F64_W-1:0] f64_t;

  typedef struct packed {
    logic [ID_MAX_W-1:0] id;
    f64_t                x;
    f64_t                y;
  } mul_op_t;

  // Binary64 multiply: RNE, subnormal in/out flushed to signed zero,
  // overflow to signed infinity, any NaN or inf*0 gives the canonical NaN.
  function automatic f64_t f64_mul(input f64_t x, input f64_t y);
    logic              sgn;
    logic [EXP_W-1:0]  ex, ey;
    logic              x_zero, y_zero, x_inf, y_inf, x_nan, y_nan;
    logic [105:0]      p;
    logic [FRAC_W-1:0] frac_raw;
    logic              g, st;
    logic [FRAC_W:0]   rsum;
    int                e;
    f64_t              r;
    sgn    = x[63] ^ y[63];
    ex     = x[62:52];
    ey     = y[62:52];
    x_zero = (ex == '0);
    y_zero = (ey == '0);
    x_inf  = (ex == EXP_MAX) && (x[51:0] == '0);
    y_inf  = (ey == EXP_MAX) && (y[51:0] == '0);
    x_nan  = (ex == EXP_MAX) && (x[51:0] != '0);
    y_nan  = (ey == EXP_MAX) && (y[51:0] != '0);
    p      = {53'b0, 1'b1, x[51:0]} * {53'b0, 1'b1, y[51:0]};
    e      = int'(ex) + int'(ey) - 1023;
    // product of two [1,2) mantissas lies in [1,4): normalise by one bit
    if (p[105]) begin
      frac_raw = p[104:53];
      g        = p[52];
      st       = |p[51:0];
      e        = e + 1;
    end else begin
      frac_raw = p[103:52];
      g        = p[51];
      st       = |p[50:0];
    end
    rsum = {1'b0, frac_raw} + 53'(g & (st | frac_raw[0]));
    // mantissa carry out of rounding: fraction already wrapped to zero
    if (rsum[FRAC_W]) e = e + 1;
    if (x_nan | y_nan | (x_inf & y_zero) | (y_inf & x_zero)) r = CANON_NAN;
    else if (x_inf | y_inf)                                  r = {sgn, EXP_MAX, 52'b0};
    else if (x_zero | y_zero)                                r = {sgn, 63'b0};
    else if (e >= 2047)                                      r = {sgn, EXP_MAX, 52'b0};
    else if (e <= 0)                                         r = {sgn, 63'b0};
    else                                                     r = {sgn, e[10:0], rsum[FRAC_W-1:0]};
    return r;
  endfunction

endpackage

// File: rtl/f64mul_pipe.sv
// LAT-stage multiplier: stage 1 captures operands, the core sits between
// stage 1 and stage LAT, id and valid travel alongside the data.
module f64mul_pipe
  import f64mul_pkg::*;
#(
  parameter int LAT = 3,
  parameter int IDW = 2
) (
  input  logic           clk_i,
  input  logic           rst_n_i,
  input  logic           in_valid_i,
  input  logic [IDW-1:0] in_id_i,
  input  f64_t           in_x_i,
  input  f64_t           in_y_i,
  output logic           out_valid_o,
  output logic [IDW-1:0] out_id_o,
  output f64_t           out_data_o
);

  logic [LAT:1] vld_pipe;
  mul_op_t      op_q;
  f64_t         prod;

  // valid bits shift one stage per cycle; the pipe never stalls
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) vld_pipe <= '0;
    else          vld_pipe <= (vld_pipe << 1) | LAT'(in_valid_i);
  end

  // stage 1 operand capture
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)        op_q <= '0;
    else if (in_valid_i) op_q <= '{id: ID_MAX_W'(in_id_i), x: in_x_i, y: in_y_i};
  end

  assign prod        = f64_mul(op_q.x, op_q.y);
  assign out_valid_o = vld_pipe[LAT];

  if (LAT == 1) begin : g_lat1
    assign out_id_o   = op_q.id[IDW-1:0];
    assign out_data_o = prod;
  end else begin : g_latn
    logic [LAT:2][F64_W-1:0] pd_q;
    logic [LAT:2][IDW-1:0]   pid_q;

    // product and id ride stages 2..LAT
    always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
        pd_q  <= '0;
        pid_q <= '0;
      end else begin
        pd_q[2]  <= prod;
        pid_q[2] <= op_q.id[IDW-1:0];
        for (int k = 3; k <= LAT; k++) begin
          pd_q[k]  <= pd_q[k-1];
          pid_q[k] <= pid_q[k-1];
        end
      end
    end

    assign out_id_o   = pid_q[LAT];
    assign out_data_o = pd_q[LAT];
  end

endmodule

// File: rtl/f64mul_share_sched.sv
// Round-robin share of one pipelined binary64 multiplier among NREQ
// requesters; results return in issue order through a credited FIFO.
module f64mul_share_sched
  import f64mul_pkg::*;
#(
  parameter int NREQ       = 4,
  parameter int LAT        = 3,
  parameter int FIFO_DEPTH = 5,
  parameter int IDW        = $clog2(NREQ)
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic [NREQ-1:0]       req_valid_i,
  output logic [NREQ-1:0]       req_ready_o,
  input  logic [NREQ*F64_W-1:0] req_x_i,
  input  logic [NREQ*F64_W-1:0] req_y_i,
  output logic                  resp_valid_o,
  input  logic                  resp_ready_i,
  output logic [IDW-1:0]        resp_id_o,
  output logic [F64_W-1:0]      resp_data_o,
  output logic                  busy_o
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int IW = $clog2(LAT + 1);

  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [IW-1:0]  infl_q, infl_d;
  logic [PW-1:0]  wr_ptr_q, rd_ptr_q;
  logic           en_q;
  logic [FIFO_DEPTH-1:0][F64_W-1:0] fdata_q;
  logic [FIFO_DEPTH-1:0][IDW-1:0]   fid_q;

  logic           gnt_vld, can_issue, issue, push, pop;
  logic [IDW-1:0] gnt_id, p_id;
  f64_t           p_data;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // first valid requester at or after rr_ptr, searching modulo NREQ
  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req_valid_i[(int'(rr_ptr_q) + k) % NREQ]) begin
        gnt_vld = 1'b1;
        gnt_id  = IDW'((int'(rr_ptr_q) + k) % NREQ);
      end
    end
  end

  // credits come from registered state only, so a pop frees a slot next cycle;
  // en_q keeps req_ready low until the first edge after reset release
  assign can_issue    = en_q && ((int'(cnt_q) + int'(infl_q)) < FIFO_DEPTH);
  assign issue        = gnt_vld & can_issue;
  assign req_ready_o  = issue ? (NREQ'(1) << gnt_id) : '0;
  assign resp_valid_o = (cnt_q != '0);
  assign pop          = resp_valid_o & resp_ready_i;
  assign resp_id_o    = fid_q[rd_ptr_q];
  assign resp_data_o  = fdata_q[rd_ptr_q];
  assign busy_o       = (infl_q != '0) | (cnt_q != '0);

  f64mul_pipe #(.LAT(LAT), .IDW(IDW)) u_pipe (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .in_valid_i (issue),
    .in_id_i    (gnt_id),
    .in_x_i     (req_x_i[int'(gnt_id)*F64_W +: F64_W]),
    .in_y_i     (req_y_i[int'(gnt_id)*F64_W +: F64_W]),
    .out_valid_o(push),
    .out_id_o   (p_id),
    .out_data_o (p_data)
  );

  // next-state for pointer, in-flight and occupancy counters
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    infl_d   = infl_q;
    cnt_d    = cnt_q;
    if (issue) rr_ptr_d = (int'(gnt_id) == NREQ - 1) ? '0 : gnt_id + 1'b1;
    case ({issue, push})
      2'b10:   infl_d = infl_q + 1'b1;
      2'b01:   infl_d = infl_q - 1'b1;
      default: infl_d = infl_q;
    endcase
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // control state
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rr_ptr_q <= '0;
      infl_q   <= '0;
      cnt_q    <= '0;
      en_q     <= 1'b0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      infl_q   <= infl_d;
      cnt_q    <= cnt_d;
      en_q     <= 1'b1;
    end
  end

  // result FIFO storage and pointers
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      fdata_q  <= '0;
      fid_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) begin
        fdata_q[wr_ptr_q] <= p_data;
        fid_q[wr_ptr_q]   <= p_id;
        wr_ptr_q          <= ptr_inc(wr_ptr_q);
      end
      if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
    end
  end

  // credits must prevent a push into a full FIFO
  a_no_ovf: assert property (@(posedge clk_i) disable iff (!rst_n_i)
    !(push && !pop && (int'(cnt_q) == FIFO_DEPTH)));

endmodule
